// File: rtl/rrv2rvh_ruby_ld_resp_align.sv
// Aligns in-order L1D line responses to outstanding ruby tester loads and emits extended 64-bit data.
// Optional watchdog enabled by defining RRV2RVH_RUBY_LD_RESP_TIMEOUT_EN.
module rrv2rvh_ruby_ld_resp_align #(
    parameter int DEPTH              = 4,
    parameter int TAG_W              = 8,
    parameter int TIMEOUT_CYCLES     = 1024,
    parameter int L1D_STB_DATA_WIDTH = 512,
    parameter int L1D_OFFSET_WIDTH   = 6,
    parameter int LDU_OP_WIDTH       = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_vld_i,
    output logic                            req_rdy_o,
    input  logic [TAG_W-1:0]                req_tag_i,
    input  logic [L1D_OFFSET_WIDTH-1:0]     req_offset_i,
    input  logic [LDU_OP_WIDTH-1:0]         req_opcode_i,
    input  logic [L1D_STB_DATA_WIDTH/8-1:0] req_byte_mask_i,
    input  logic                            resp_vld_i,
    output logic                            resp_rdy_o,
    input  logic [L1D_STB_DATA_WIDTH-1:0]   resp_line_data_i,
    output logic                            out_vld_o,
    input  logic                            out_rdy_i,
    output logic [TAG_W-1:0]                out_tag_o,
    output logic [63:0]                     out_data_o,
    output logic                            err_timeout_o
);

    localparam int MASK_W = L1D_STB_DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int ENT_W  = TAG_W + L1D_OFFSET_WIDTH + LDU_OP_WIDTH + MASK_W;
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    // Load opcode encoding shared with the ldu decoder; anything else returns zero data.
    localparam logic [LDU_OP_WIDTH-1:0] LDU_LB  = LDU_OP_WIDTH'(0);
    localparam logic [LDU_OP_WIDTH-1:0] LDU_LH  = LDU_OP_WIDTH'(1);
    localparam logic [LDU_OP_WIDTH-1:0] LDU_LW  = LDU_OP_WIDTH'(2);
    localparam logic [LDU_OP_WIDTH-1:0] LDU_LD  = LDU_OP_WIDTH'(3);
    localparam logic [LDU_OP_WIDTH-1:0] LDU_LBU = LDU_OP_WIDTH'(4);
    localparam logic [LDU_OP_WIDTH-1:0] LDU_LHU = LDU_OP_WIDTH'(5);
    localparam logic [LDU_OP_WIDTH-1:0] LDU_LWU = LDU_OP_WIDTH'(6);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ENT_W-1:0] fifo_mem_q [DEPTH];
    logic             full, empty, push, pop;

    logic [TAG_W-1:0]              head_tag;
    logic [L1D_OFFSET_WIDTH-1:0]   head_off;
    logic [LDU_OP_WIDTH-1:0]       head_op;
    logic [MASK_W-1:0]             head_mask;

    logic [L1D_STB_DATA_WIDTH-1:0] line_bit_mask;
    logic [L1D_STB_DATA_WIDTH-1:0] masked_line;
    logic [63:0]                   raw_data;
    logic [63:0]                   ext_data;
    logic                          op_b, op_hw, op_w, op_dw, op_sign;

    logic             out_vld_q, out_vld_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [63:0]      out_data_q, out_data_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign req_rdy_o  = !full;
    assign resp_rdy_o = !empty && (!out_vld_q || out_rdy_i);
    assign push       = req_vld_i && !full;
    assign pop        = resp_vld_i && resp_rdy_o;

    assign {head_tag, head_off, head_op, head_mask} = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {req_tag_i, req_offset_i, req_opcode_i, req_byte_mask_i};
        end
    end

    always_comb begin
        line_bit_mask = '0;
        for (int b = 0; b < MASK_W; b++) begin
            line_bit_mask[b*8 +: 8] = {8{head_mask[b]}};
        end
        masked_line = resp_line_data_i & line_bit_mask;
        raw_data    = 64'(masked_line >> {head_off, 3'b000});
    end

    always_comb begin
        op_b    = 1'b0;
        op_hw   = 1'b0;
        op_w    = 1'b0;
        op_dw   = 1'b0;
        op_sign = 1'b0;
        case (head_op)
            LDU_LB:  begin op_b  = 1'b1; op_sign = 1'b1; end
            LDU_LH:  begin op_hw = 1'b1; op_sign = 1'b1; end
            LDU_LW:  begin op_w  = 1'b1; op_sign = 1'b1; end
            LDU_LD:  op_dw = 1'b1;
            LDU_LBU: op_b  = 1'b1;
            LDU_LHU: op_hw = 1'b1;
            LDU_LWU: op_w  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        ext_data = '0;
        if (op_b) begin
            ext_data = {{56{op_sign & raw_data[7]}}, raw_data[7:0]};
        end else if (op_hw) begin
            ext_data = {{48{op_sign & raw_data[15]}}, raw_data[15:0]};
        end else if (op_w) begin
            ext_data = {{32{op_sign & raw_data[31]}}, raw_data[31:0]};
        end else if (op_dw) begin
            ext_data = raw_data;
        end
    end

    // A new result may overwrite the register in the same edge the old one drains.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_tag_d  = out_tag_q;
        out_data_d = out_data_q;
        if (pop) begin
            out_vld_d  = 1'b1;
            out_tag_d  = head_tag;
            out_data_d = ext_data;
        end else if (out_rdy_i) begin
            out_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_vld_q  <= 1'b0;
            out_tag_q  <= '0;
            out_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_vld_q  <= out_vld_d;
            out_tag_q  <= out_tag_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_vld_o  = out_vld_q;
    assign out_tag_o  = out_tag_q;
    assign out_data_o = out_data_q;

`ifdef RRV2RVH_RUBY_LD_RESP_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic            err_timeout_q, err_timeout_d;

    // Counts stalled cycles with loads outstanding; saturates at the limit.
    always_comb begin
        wdog_cnt_d    = wdog_cnt_q;
        err_timeout_d = err_timeout_q;
        if (empty || pop) begin
            wdog_cnt_d = '0;
        end else if (wdog_cnt_q != WD_LIMIT) begin
            wdog_cnt_d = wdog_cnt_q + WD_ONE;
        end
        if (wdog_cnt_d == WD_LIMIT) begin
            err_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wdog_cnt_q    <= wdog_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout_o = err_timeout_q;
`else
    assign err_timeout_o = 1'b0;
`endif

endmodule
